// File: rtl/ubrbs_seq_14_0_11_0.sv
// ubrbs_seq_14_0_11_0: sequential 15-bit minus 12-bit subtractor.
// Processes one 4-bit block per cycle (blocks 4/4/4/3). Inside a block, borrows
// come from look-ahead terms. Between blocks, the borrow ripples through a register.
// Optional zero flag: define UBRBS_ZERO_FLAG_EN.
module ubrbs_seq_14_0_11_0 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] x,
  input  logic [11:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] d,
  output logic        bout
`ifdef UBRBS_ZERO_FLAG_EN
  ,
  output logic        zero
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic [14:0] xr, yr;
  logic [1:0]  k;
  logic        br;

  logic [15:0] xp, yp;
  logic [3:0]  xb, yb, g, p, dblk;
  logic [4:0]  b;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Block k operand slice and parallel borrow look-ahead.
  // Bit 15 is padded with 0 in both operands, so for block 3 that bit has G=0 and P=1.
  // As a result, b[4] equals the borrow out of bit 14.
  always_comb begin
    xp   = {1'b0, xr};
    yp   = {1'b0, yr};
    xb   = xp[{k, 2'b00} +: 4];
    yb   = yp[{k, 2'b00} +: 4];
    g    = ~xb & yb;
    p    = ~(xb ^ yb);
    b[0] = br;
    b[1] = g[0] | (p[0] & br);
    b[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br);
    b[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & br);
    b[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & br);
    dblk = xb ^ yb ^ b[3:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)      state_nx = RUN;
      RUN:     if (k == 2'd3)     state_nx = DONE;
      DONE:    if (out_ready)     state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // Operand capture, per-block difference write-back and borrow ripple.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr   <= '0;
      yr   <= '0;
      k    <= '0;
      br   <= 1'b0;
      d    <= '0;
      bout <= 1'b0;
`ifdef UBRBS_ZERO_FLAG_EN
      zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr <= x;
            yr <= {3'b000, y};
            br <= 1'b0;
            k  <= '0;
          end
        end
        RUN: begin
          br <= b[4];
          case (k)
            2'd0: d[3:0]   <= dblk;
            2'd1: d[7:4]   <= dblk;
            2'd2: d[11:8]  <= dblk;
            2'd3: d[14:12] <= dblk[2:0];
          endcase
          if (k == 2'd3) begin
            bout <= b[4];
`ifdef UBRBS_ZERO_FLAG_EN
            zero <= ({dblk[2:0], d[11:0]} == 15'd0);
`endif
          end else begin
            k <= k + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ubrbs_seq_14_0_11_0.sv
// Testbench for ubrbs_seq_14_0_11_0.
// It runs directed vectors, then randomized operations with backpressure and a reset abort.
// Results are compared against an arithmetic reference model.
module tb_ubrbs_seq_14_0_11_0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] x = '0;
  logic [11:0] y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [14:0] d;
  logic        bout;
`ifdef UBRBS_ZERO_FLAG_EN
  logic        zero;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  ubrbs_seq_14_0_11_0 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout)
`ifdef UBRBS_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One operation: accept, wait for result with latency check, optional backpressure hold.
  task automatic do_op(input logic [14:0] xa, input logic [11:0] ya, input int unsigned hold);
    int unsigned exp_d, exp_b, n;
    exp_d = (32'(xa) + 32'h8000 - 32'(ya)) % 32'h8000;
    exp_b = (32'(xa) < 32'(ya)) ? 1 : 0;
    out_ready = (hold == 0);
    @(negedge clk);
    check("in_ready_before", 32'(in_ready), 1);
    in_valid = 1'b1; x = xa; y = ya;
    @(posedge clk); #1;
    in_valid = 1'b0; x = 15'($urandom); y = 12'($urandom);
    n = 0;
    while (n < 8) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) break;
    end
    check("latency", n, 4);
    check("d", 32'(d), exp_d);
    check("bout", 32'(bout), exp_b);
`ifdef UBRBS_ZERO_FLAG_EN
    check("zero", 32'(zero), (exp_d == 0) ? 1 : 0);
`endif
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = 15'($urandom); y = 12'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold_d", 32'(d), exp_d);
      check("hold_bout", 32'(bout), exp_b);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_in_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 32'(in_ready), 1);
    check("release_valid", 32'(out_valid), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_d", 32'(d), 0);
    check("rst_bout", 32'(bout), 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors
    do_op(15'h7FFF, 12'hFFF, 0);
    do_op(15'h0000, 12'h001, 0);
    do_op(15'h1000, 12'h001, 0);
    do_op(15'h0ABC, 12'hABC, 0);
    do_op(15'h0ABD, 12'hABC, 0);
    do_op(15'h0123, 12'h456, 10);

    // Reset abort during RUN at k=2
    @(negedge clk);
    in_valid = 1'b1; x = 15'h7123; y = 12'h0FF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_d", 32'(d), 0);
    @(negedge clk); rst_n = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_abort_valid", 32'(out_valid), 0);
    end
    do_op(15'h0005, 12'h003, 0);

    // Randomized operations
    for (int unsigned i = 0; i < 40; i++) begin
      logic [14:0] rx;
      logic [11:0] ry;
      rx = 15'($urandom);
      ry = 12'($urandom);
      if (i % 8 == 1) rx = 15'(ry);
      if (i % 8 == 2) rx = 15'($urandom_range(0, 15));
      do_op(rx, ry, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ubrbs_seq_14_0_11_0.md
UBRBS_SEQ_14_0_11_0 -- requirements
Module: ubrbs_seq_14_0_11_0

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at X 15 bits, Y 12 bits, block size 4/4/4/3.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair x/y offered.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 x  input  15  minuend, unsigned.
REQ-007 y  input  12  subtrahend, unsigned, zero-extended to 15 bits internally.
REQ-008 out_valid  output  1  result d/bout available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 d  output  15  difference (x - y) mod 2^15.
REQ-011 bout  output  1  final borrow; 1 iff x < y.
REQ-012 zero  output  1  present only with UBRBS_ZERO_FLAG_EN; 1 iff d == 0.

Function
REQ-013 The block SHALL implement states IDLE, RUN, DONE; in_ready = (state == IDLE), out_valid = (state == DONE).
REQ-014 IDLE: on in_valid && in_ready at an edge, the block SHALL register x and zero-extended y, clear borrow register, set block index k = 0, go to RUN.
REQ-015 RUN: each cycle the block SHALL process block k (bits 4k..4k+3; k = 3 covers bits 14:12 only) using borrow look-ahead: G_i = ~x_i & y_i, P_i = ~(x_i ^ y_i), b_(i+1) = G_i | (P_i & b_i), d_i = x_i ^ y_i ^ b_i, with b_0 of the block = registered borrow.
REQ-016 Within a block all internal borrows SHALL be computed from G/P/block borrow-in in parallel (no bit-to-bit ripple); between blocks the borrow SHALL ripple through the borrow register, one block per cycle.
REQ-017 RUN SHALL last exactly 4 cycles; at the 4th edge the block SHALL load bout from block 3 borrow-out and go to DONE, so out_valid rises 4 edges after the accepting edge.
REQ-018 DONE: d, bout (and zero) SHALL remain stable until out_valid && out_ready; at that edge state SHALL return to IDLE.
REQ-019 in_valid SHALL be ignored in RUN and DONE; no same-cycle accept on DONE exit; steady-state throughput one result per 6 cycles with out_ready held high.
REQ-020 d bits of blocks not yet processed SHALL not be observable: out_valid low implies consumer ignores d.
REQ-021 x and y changing after acceptance SHALL not affect the result.

Reset
REQ-022 rst_n low SHALL asynchronously force state IDLE, k = 0, borrow = 0, d = 0, bout = 0, zero = 0; out_valid = 0, in_ready = 1.
REQ-023 Reset asserted during RUN or DONE SHALL abort the operation with no result ever presented; first operation after release SHALL be computed correctly.

Configuration
REQ-024 With UBRBS_ZERO_FLAG_EN defined, port zero and its register SHALL exist, zero registered at the DONE transition as d == 0 and held with d.
REQ-025 Without UBRBS_ZERO_FLAG_EN, port zero and all associated logic SHALL be absent; all other behaviour identical.

Verification
REQ-026 x=0x7FFF, y=0xFFF, out_ready=1 -> out_valid exactly 4 edges after accept, d=0x7000, bout=0.
REQ-027 x=0x0000, y=0x001 -> d=0x7FFF, bout=1 (borrow through all four blocks).
REQ-028 x=0x1000, y=0x001 -> d=0x0FFF, bout=0 (borrow crosses blocks 0-2 into block 3).
REQ-029 out_ready low 10 cycles after out_valid, in_valid pulsed with new operands -> d/bout stable, in_ready=0, new operands ignored; after out_ready=1 one edge, in_ready=1.
REQ-030 rst_n low during RUN at k=2 -> out_valid stays 0, in_ready=1 after release; next pair x=0x0005, y=0x003 -> d=0x0002, bout=0.
REQ-031 With UBRBS_ZERO_FLAG_EN: x=0x0ABC, y=0xABC -> d=0x0000, zero=1, bout=0; x=0x0ABD, y=0xABC -> zero=0.
